// File: rtl/fetch_unit_if.sv
// Instruction-memory read port: req/addr out from the fetch stage, ack/data back.
interface fetch_unit_if;
  logic        i_req_o;
  logic [31:0] i_addr_o;
  logic        i_ack_i;
  logic [31:0] i_data_i;

  modport master (
    output i_req_o,
    output i_addr_o,
    input  i_ack_i,
    input  i_data_i
  );

  modport slave (
    input  i_req_o,
    input  i_addr_o,
    output i_ack_i,
    output i_data_i
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, reads one word per instruction over a
// req/ack port, presents it to the decoder for one or more EXEC cycles and
// computes the next PC from the decoder's selection. Halts on a misaligned target.
// Optional bus timeout guarded by macro FETCH_TIMEOUT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         stall_i,
  fetch_unit_if.master imem,
  output logic [31:0]  instr_o,
  output logic         instr_valid_o,
  output logic [31:0]  pc_o,
  output logic [31:0]  pc_plus4_o,
  input  logic [1:0]   next_pc_sel_i,
  input  logic [31:0]  addr_i,
  output logic         fault_o,
  output logic [1:0]   fault_cause_o
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR      = 32'h0000_0013;
  localparam logic [1:0]      CAUSE_NONE     = 2'b00;
  localparam logic [1:0]      CAUSE_MISALIGN = 2'b01;

  // Elaboration-time parameter sanity checks
  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("fetch_unit: RESET_PC must be word aligned");
  end
  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("fetch_unit: TIMEOUT_CYCLES must be within 1..65535");
  end

  typedef enum logic [1:0] {
    S_BOOT  = 2'b00,
    S_FETCH = 2'b01,
    S_EXEC  = 2'b10,
    S_HALT  = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic              req_q, req_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;
  logic [1:0]        cause_q, cause_d;
  logic [XLEN-1:0]   target;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W         = 16;
  localparam logic [1:0]  CAUSE_TIMEOUT = 2'b10;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Next-PC selection from the decoder; 2'b10 falls back to sequential
  always_comb begin
    target = pc_q + 32'd4;
    case (next_pc_sel_i)
      2'b01:   target = pc_q + addr_i;
      2'b11:   target = addr_i;
      default: target = pc_q + 32'd4;
    endcase
  end

  // Next-state and next-register logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    fault_d = fault_q;
    cause_d = cause_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_BOOT: begin
        state_d = S_FETCH;
`ifdef FETCH_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_FETCH: begin
        if (imem.i_ack_i) begin
          instr_d = imem.i_data_i;
          state_d = S_EXEC;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          fault_d = 1'b1;
          cause_d = CAUSE_TIMEOUT;
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_EXEC: begin
        if (!stall_i) begin
          if (target[1:0] != 2'b00) begin
            fault_d = 1'b1;
            cause_d = CAUSE_MISALIGN;
            state_d = S_HALT;
          end else begin
            pc_d    = target;
            state_d = S_FETCH;
`ifdef FETCH_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      default: state_d = S_HALT;
    endcase
    req_d   = (state_d == S_FETCH);
    valid_d = (state_d == S_EXEC);
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      cause_q <= CAUSE_NONE;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      cause_q <= cause_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign imem.i_req_o  = req_q;
  assign imem.i_addr_o = pc_q;
  assign instr_o       = instr_q;
  assign instr_valid_o = valid_q;
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_q + 32'd4;
  assign fault_o       = fault_q;
  assign fault_cause_o = cause_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table of per-instruction vectors plus
// hand-written misaligned-halt, async-reset and (optional) timeout sequences.
module tb_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        stall_i;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic [1:0]  next_pc_sel_i;
  logic [31:0] addr_i;
  logic        fault_o;
  logic [1:0]  fault_cause_o;

  fetch_unit_if imem();

  fetch_unit #(
    .RESET_PC       (32'h0000_0000),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .stall_i       (stall_i),
    .imem          (imem),
    .instr_o       (instr_o),
    .instr_valid_o (instr_valid_o),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o),
    .next_pc_sel_i (next_pc_sel_i),
    .addr_i        (addr_i),
    .fault_o       (fault_o),
    .fault_cause_o (fault_cause_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc;       // expected fetch address
    int          wait_c;   // cycles before ack
    int          stall_c;  // stalled EXEC cycles
    logic [1:0]  sel;
    logic [31:0] addr;
    logic [31:0] next_pc;  // expected next fetch address
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0003;
  endfunction

  task automatic check_reset_vals(input string tag);
    check1 ({tag, "_req"},   imem.i_req_o, 1'b0);
    check1 ({tag, "_valid"}, instr_valid_o, 1'b0);
    check32({tag, "_addr"},  imem.i_addr_o, 32'h0);
    check32({tag, "_pc"},    pc_o, 32'h0);
    check32({tag, "_pc4"},   pc_plus4_o, 32'h4);
    check32({tag, "_instr"}, instr_o, 32'h0000_0013);
    check1 ({tag, "_fault"}, fault_o, 1'b0);
    check32({tag, "_cause"}, 32'(fault_cause_o), 32'h0);
  endtask

  // One instruction: wait states, ack, EXEC with stalls, then next fetch address
  task automatic run_instr(input vec_t v);
    for (int w = 0; w < v.wait_c; w++) begin
      check1 ("wait_req",   imem.i_req_o, 1'b1);
      check32("wait_addr",  imem.i_addr_o, v.pc);
      check1 ("wait_valid", instr_valid_o, 1'b0);
      imem.i_ack_i  = 1'b0;
      imem.i_data_i = 32'hFFFF_FFFF;
      step();
    end
    check1 ("fetch_req",  imem.i_req_o, 1'b1);
    check32("fetch_addr", imem.i_addr_o, v.pc);
    imem.i_ack_i  = 1'b1;
    imem.i_data_i = mem_word(v.pc);
    step();
    for (int s = 0; s <= v.stall_c; s++) begin
      check1 ("exec_valid", instr_valid_o, 1'b1);
      check1 ("exec_req",   imem.i_req_o, 1'b0);
      check32("exec_instr", instr_o, mem_word(v.pc));
      check32("exec_pc",    pc_o, v.pc);
      check32("exec_pc4",   pc_plus4_o, v.pc + 32'd4);
      if (s < v.stall_c) begin
        // stalled: decoder inputs and a stray ack must both be ignored
        stall_i       = 1'b1;
        next_pc_sel_i = 2'b11;
        addr_i        = 32'h0000_0003;
        imem.i_ack_i  = 1'b1;
        imem.i_data_i = 32'hBAD0_BAD0;
      end else begin
        stall_i       = 1'b0;
        next_pc_sel_i = v.sel;
        addr_i        = v.addr;
        imem.i_ack_i  = 1'b0;
      end
      step();
    end
    next_pc_sel_i = 2'b00;
    addr_i        = 32'h0;
    check1 ("next_req",   imem.i_req_o, 1'b1);
    check32("next_addr",  imem.i_addr_o, v.next_pc);
    check1 ("next_valid", instr_valid_o, 1'b0);
  endtask

  initial begin
    vec_t v0;
    rst_ni        = 1'b0;
    stall_i       = 1'b0;
    next_pc_sel_i = 2'b00;
    addr_i        = 32'h0;
    imem.i_ack_i  = 1'b0;
    imem.i_data_i = 32'h0;

    vecs[0]  = '{32'h0000_0000, 0, 0, 2'b00, 32'h0000_0000, 32'h0000_0004};
    vecs[1]  = '{32'h0000_0004, 0, 0, 2'b00, 32'h0000_0000, 32'h0000_0008};
    vecs[2]  = '{32'h0000_0008, 3, 2, 2'b10, 32'h1234_5678, 32'h0000_000C};
    vecs[3]  = '{32'h0000_000C, 0, 0, 2'b11, 32'h0000_0100, 32'h0000_0100};
    vecs[4]  = '{32'h0000_0100, 0, 0, 2'b01, 32'hFFFF_FFF8, 32'h0000_00F8};
    vecs[5]  = '{32'h0000_00F8, 1, 0, 2'b11, 32'h0000_2000, 32'h0000_2000};
    vecs[6]  = '{32'h0000_2000, 0, 1, 2'b11, 32'h0000_0100, 32'h0000_0100};
    vecs[7]  = '{32'h0000_0100, 0, 0, 2'b10, 32'h0000_0040, 32'h0000_0104};
    vecs[8]  = '{32'h0000_0104, 0, 0, 2'b11, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
    vecs[9]  = '{32'hFFFF_FFFC, 0, 0, 2'b00, 32'h0000_0000, 32'h0000_0000};
    vecs[10] = '{32'h0000_0000, 2, 0, 2'b01, 32'h0000_01FC, 32'h0000_01FC};

    // Reset values while held in reset
    step();
    step();
    check_reset_vals("rst");

    // Release: one BOOT cycle, then first request to RESET_PC
    rst_ni = 1'b1;
    step();
    for (int i = 0; i < NVEC; i++) run_instr(vecs[i]);

    // Misaligned target: fetch at 0x1FC, then jump to 0x202
    imem.i_ack_i  = 1'b1;
    imem.i_data_i = mem_word(32'h0000_01FC);
    step();
    imem.i_ack_i  = 1'b0;
    check1("mis_exec_valid", instr_valid_o, 1'b1);
    next_pc_sel_i = 2'b11;
    addr_i        = 32'h0000_0202;
    step();
    next_pc_sel_i = 2'b00;
    addr_i        = 32'h0;
    check1 ("mis_fault", fault_o, 1'b1);
    check32("mis_cause", 32'(fault_cause_o), 32'h1);
    check1 ("mis_req",   imem.i_req_o, 1'b0);
    check1 ("mis_valid", instr_valid_o, 1'b0);
    check32("mis_pc",    pc_o, 32'h0000_01FC);
    for (int i = 0; i < 22; i++) begin
      imem.i_ack_i  = i[0];
      imem.i_data_i = $urandom;
      step();
      check1 ("halt_req",   imem.i_req_o, 1'b0);
      check1 ("halt_valid", instr_valid_o, 1'b0);
      check32("halt_pc",    pc_o, 32'h0000_01FC);
      check32("halt_instr", instr_o, mem_word(32'h0000_01FC));
      check1 ("halt_fault", fault_o, 1'b1);
      check32("halt_cause", 32'(fault_cause_o), 32'h1);
    end
    imem.i_ack_i = 1'b0;

    // Reset out of HALT, run one instruction, then assert reset mid-FETCH
    rst_ni = 1'b0;
    #1;
    check_reset_vals("rst_halt");
    step();
    rst_ni = 1'b1;
    step();
    v0 = '{32'h0000_0000, 0, 0, 2'b00, 32'h0, 32'h0000_0004};
    run_instr(v0);
    step();
    step();
    check1 ("pre_async_req",  imem.i_req_o, 1'b1);
    check32("pre_async_addr", imem.i_addr_o, 32'h0000_0004);
    #2;
    rst_ni = 1'b0;
    #1;
    check_reset_vals("async");
    step();
    rst_ni = 1'b1;
    check1("boot_req", imem.i_req_o, 1'b0);
    step();
    check1 ("restart_req",  imem.i_req_o, 1'b1);
    check32("restart_addr", imem.i_addr_o, 32'h0);

`ifdef FETCH_TIMEOUT_EN
    // No ack: fault after the 8th waiting FETCH cycle
    for (int k = 1; k <= 8; k++) begin
      check1("to_wait_req", imem.i_req_o, 1'b1);
      check1("to_wait_fault", fault_o, 1'b0);
      imem.i_ack_i = 1'b0;
      step();
    end
    check1 ("to_fault", fault_o, 1'b1);
    check32("to_cause", 32'(fault_cause_o), 32'h2);
    check1 ("to_req",   imem.i_req_o, 1'b0);
    check1 ("to_valid", instr_valid_o, 1'b0);

    // Ack on exactly the 8th FETCH cycle wins over the timeout
    rst_ni = 1'b0;
    #1;
    check1("to_rst_fault", fault_o, 1'b0);
    step();
    rst_ni = 1'b1;
    step();
    for (int k = 1; k <= 7; k++) begin
      check1("late_wait_req", imem.i_req_o, 1'b1);
      imem.i_ack_i = 1'b0;
      step();
    end
    check1("late_req", imem.i_req_o, 1'b1);
    imem.i_ack_i  = 1'b1;
    imem.i_data_i = mem_word(32'h0);
    step();
    imem.i_ack_i = 1'b0;
    check1 ("late_valid", instr_valid_o, 1'b1);
    check1 ("late_fault", fault_o, 1'b0);
    check32("late_cause", 32'(fault_cause_o), 32'h0);
    check32("late_instr", instr_o, mem_word(32'h0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage feeding the decoder. Holds the program counter, issues one instruction-memory read per instruction over a req/ack handshake, and presents the fetched word with a one-cycle valid strobe to the decoder's `en_i`/`instr_i` inputs. It consumes the decoder's `next_pc_sel_o`/`addr_o` results to compute the next PC, and halts on a misaligned control-flow target.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word aligned.
- `TIMEOUT_CYCLES`, default 255: maximum FETCH wait cycles before fault. Used only with `FETCH_TIMEOUT_EN`; range 1..65535.
- `clk_i`, in, 1: clock; all state updates on the rising edge.
- `rst_ni`, in, 1: asynchronous, active-low reset.
- `stall_i`, in, 1: holds the current instruction in EXEC.
- `i_req_o`, out, 1: instruction read request.
- `i_addr_o`, out, 32: read address; equals `pc_o`.
- `i_ack_i`, in, 1: read complete; `i_data_i` is valid in the same cycle.
- `i_data_i`, in, 32: instruction word.
- `instr_o`, out, 32: latched instruction, to decoder `instr_i`.
- `instr_valid_o`, out, 1: instruction valid, to decoder `en_i`.
- `pc_o`, out, 32: PC of `instr_o`.
- `pc_plus4_o`, out, 32: `pc_o + 4`, for the register-file write source.
- `next_pc_sel_i`, in, 2: from the decoder. 00: PC+4; 01: PC+`addr_i`; 11: `addr_i`; 10: treated as 00.
- `addr_i`, in, 32: target or offset from the decoder.
- `fault_o`, out, 1: sticky fault flag.
- `fault_cause_o`, out, 2: 00 none; 01 misaligned target; 10 bus timeout.

## Operation
- States: BOOT, FETCH, EXEC, HALT. Reset state is BOOT.
- **BOOT**: one cycle, then FETCH.
- **FETCH**:
  - `i_req_o`=1 and `i_addr_o`=`pc_o`.
  - On `i_ack_i`=1: latch `i_data_i` into `instr_o`, go to EXEC.
  - Otherwise remain in FETCH with the request held.
- **EXEC**:
  - `instr_valid_o`=1 and `i_req_o`=0.
  - If `stall_i`=1: remain in EXEC; `instr_o` and `pc_o` are held and `instr_valid_o` stays 1.
  - If `stall_i`=0: compute the target `t` from `next_pc_sel_i`.
    - If `t[1:0]`≠0: set `fault_o`, set `fault_cause_o`=01, leave the PC unchanged, go to HALT.
    - Otherwise: `pc_o`←`t`, go to FETCH.
- **HALT**: all request and valid outputs are 0. Only reset leaves HALT.
- Arithmetic: 32-bit modulo; PC+4 and PC+`addr_i` wrap silently. Example: 32'hFFFF_FFFC+4 = 0.
- `i_ack_i` outside FETCH is ignored; `i_data_i` is not sampled.
- `pc_plus4_o` is combinational from `pc_o`.
- Reset values:
  - `pc_o`=`RESET_PC`
  - `instr_o`=32'h0000_0013 (NOP)
  - `instr_valid_o`=0, `i_req_o`=0
  - `fault_o`=0, `fault_cause_o`=00
  - wait counter = 0
- Reset asserted mid-operation: all of the above take effect immediately and asynchronously. A pending request is dropped; the memory side must tolerate an abandoned request.

## Timing
- `i_req_o`, `i_addr_o` and `instr_valid_o` are decoded from registered state only. There is no combinational path from `i_ack_i`.
- Cycles per instruction = 1 (FETCH with ack in its first cycle) + wait cycles + 1 (EXEC) + stall cycles. Minimum is 2.
- `instr_o` is valid from the cycle after ack through the end of EXEC.
- The decoder's outputs are sampled at the EXEC→FETCH edge. The new PC appears on `i_addr_o` in the next cycle.
- After `rst_ni` deasserts: 1 BOOT cycle, then the first request to `RESET_PC`.

## Configuration
- Macro `FETCH_TIMEOUT_EN`.
- **Defined**:
  - A 16-bit counter clears on FETCH entry and increments each FETCH cycle without ack.
  - When the counter reaches `TIMEOUT_CYCLES` without ack: `fault_o`=1, `fault_cause_o`=10, go to HALT, `i_req_o` drops.
  - An ack arriving in the same cycle the limit is reached wins: no fault.
- **Not defined**: there is no counter, and FETCH waits indefinitely. Cause 10 never occurs.

## Test plan
- **Reset and sequential fetch**: reset with `RESET_PC`=0, memory acks immediately, decoder sel=00 → `i_addr_o` sequence 0, 4, 8, one instruction every 2 cycles, `instr_valid_o` pulses of 1 cycle.
- **Wait states plus stall**: ack delayed 3 cycles, `stall_i` high for 2 EXEC cycles → 4 FETCH cycles plus 3 EXEC cycles; `instr_o` and `pc_o` stable throughout.
- **Control flow**: at PC 0x100, sel=01 with `addr_i`=0xFFFF_FFF8 → next fetch at 0xF8. Sel=11 with `addr_i`=0x2000 → next fetch at 0x2000. Sel=10 → 0x104.
- **Misaligned target**: sel=11, `addr_i`=0x202 → `fault_o`=1, cause 01, HALT, `i_req_o` stays 0 for 20 or more cycles, `pc_o` unchanged.
- **Timeout** (macro defined, `TIMEOUT_CYCLES`=8):
  - No ack → fault at the 8th wait cycle, cause 10.
  - Ack on exactly the 8th cycle → no fault.
- **Async reset mid-FETCH**: `rst_ni` low while in FETCH → all outputs return to their reset values within the same cycle, and fetch restarts at `RESET_PC`.
